aes_round_sched: RTL and testbench

Round sequencer for the AES cipher core. Accepts one block-load request at a time from the host side and steps the shared round datapath through the initial AddRoundKey, NR rounds and output hand-off. Drives the round counter, round constant (rcon), datapath enables and mux selects. Sits between the host interface and the round/key-expansion logic of the cipher top.

---
 rtl/aes_round_sched.sv | 184 ++++++++++++++++++
 tb/tb_aes_round_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// -----------------------------------------------------------------------------
// aes_round_sched
//
// Round sequencer for the AES cipher core. Accepts one block-load request at a
// time and steps the shared round datapath through the initial AddRoundKey
// (INIT), NR cipher rounds (ROUND) and the result hand-off (OUT). It drives the
// round counter, the key-expansion round constant, the datapath load enables
// and the INIT mux select.
//
// Parameters
//   NR          number of cipher rounds, 10..14 (default 10)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   ld          load request (key and text presented by the host)
//   in_ready    block can be accepted; a load is taken on ld && in_ready
//   abort       synchronous cancel of the block in flight
//   out_ready   downstream accepts the result (used only in hold mode)
//   out_valid   result on the datapath is valid
//   busy        a block is in flight or being held
//   round       current round index, 0 during INIT
//   rcon        round constant for the current round's key-expansion step
//   sel_init    datapath takes text ^ key instead of the round output
//   last_round  current round skips MixColumns
//   state_en    datapath state register load enable
//   kexp_en     key-expansion register load enable
//
// Configuration macro
//   AES_SCHED_OUT_HOLD_EN  when defined, OUT holds out_valid until out_ready;
//                          when undefined, out_valid is a one-cycle pulse and
//                          out_ready is ignored.
// -----------------------------------------------------------------------------
module aes_round_sched #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  output logic       in_ready,
  input  logic       abort,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       busy,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       sel_init,
  output logic       last_round,
  output logic       state_en,
  output logic       kexp_en
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q,  rcon_d;

  logic sel_init_q,   sel_init_d;
  logic last_round_q, last_round_d;
  logic state_en_q,   state_en_d;
  logic kexp_en_q,    kexp_en_d;
  logic out_valid_q,  out_valid_d;
  logic busy_q,       busy_d;

  logic out_exit;

  // GF(2^8) multiply by x, reduction polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_SCHED_OUT_HOLD_EN
  assign out_exit = out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign out_exit         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;

    unique case (state_q)
      S_IDLE: begin
        round_d = 4'd0;
        rcon_d  = 8'h00;
        // abort has priority over a simultaneous load
        if (ld && !abort) state_d = S_INIT;
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
          round_d = 4'd0;
          rcon_d  = 8'h00;
        end else begin
          state_d = S_ROUND;
          round_d = 4'd1;
          rcon_d  = 8'h01;
        end
      end
      S_ROUND: begin
        if (abort) begin
          state_d = S_IDLE;
          round_d = 4'd0;
          rcon_d  = 8'h00;
        end else if (round_q == NR_L) begin
          // round/rcon hold through OUT so the last values stay visible
          state_d = S_OUT;
        end else begin
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
        end
      end
      S_OUT: begin
        if (abort || out_exit) begin
          state_d = S_IDLE;
          round_d = 4'd0;
          rcon_d  = 8'h00;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
        rcon_d  = 8'h00;
      end
    endcase

    // Outputs are registered copies of the next-state decode, so they change
    // only on clock edges and never see ld/abort/out_ready combinationally.
    sel_init_d   = (state_d == S_INIT);
    state_en_d   = (state_d == S_INIT) || (state_d == S_ROUND);
    kexp_en_d    = (state_d == S_ROUND);
    last_round_d = (state_d == S_ROUND) && (round_d == NR_L);
    out_valid_d  = (state_d == S_OUT);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      round_q      <= 4'd0;
      rcon_q       <= 8'h00;
      sel_init_q   <= 1'b0;
      last_round_q <= 1'b0;
      state_en_q   <= 1'b0;
      kexp_en_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      sel_init_q   <= sel_init_d;
      last_round_q <= last_round_d;
      state_en_q   <= state_en_d;
      kexp_en_q    <= kexp_en_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  // in_ready is the only output with a combinational input term (abort);
  // gating with rst keeps it low while reset is asserted.
  assign in_ready   = rst && (state_q == S_IDLE) && !abort;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign round      = round_q;
  assign rcon       = rcon_q;
  assign sel_init   = sel_init_q;
  assign last_round = last_round_q;
  assign state_en   = state_en_q;
  assign kexp_en    = kexp_en_q;

endmodule

// File: tb/tb_aes_round_sched.sv
module tb_aes_round_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ld, ld14, abort, out_ready;

  logic       a_in_ready, a_out_valid, a_busy, a_sel_init, a_last_round, a_state_en, a_kexp_en;
  logic [3:0] a_round;
  logic [7:0] a_rcon;
  logic       b_in_ready, b_out_valid, b_busy, b_sel_init, b_last_round, b_state_en, b_kexp_en;
  logic [3:0] b_round;
  logic [7:0] b_rcon;

  aes_round_sched #(.NR(10)) dut (
    .clk(clk), .rst(rst), .ld(ld), .in_ready(a_in_ready), .abort(abort),
    .out_ready(out_ready), .out_valid(a_out_valid), .busy(a_busy),
    .round(a_round), .rcon(a_rcon), .sel_init(a_sel_init),
    .last_round(a_last_round), .state_en(a_state_en), .kexp_en(a_kexp_en)
  );

  aes_round_sched #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .ld(ld14), .in_ready(b_in_ready), .abort(abort),
    .out_ready(out_ready), .out_valid(b_out_valid), .busy(b_busy),
    .round(b_round), .rcon(b_rcon), .sel_init(b_sel_init),
    .last_round(b_last_round), .state_en(b_state_en), .kexp_en(b_kexp_en)
  );

`ifdef AES_SCHED_OUT_HOLD_EN
  localparam int HOLD = 7;
`else
  localparam int HOLD = 0;
`endif

  // rcon per round index, taken from the AES key schedule
  localparam logic [7:0] RCON_T [0:14] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                           8'h10, 8'h20, 8'h40, 8'h80, 8'h1b,
                                           8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  int vectors = 0;
  int miscompares = 0;
  logic [18:0] sb[$];
  bit use14 = 1'b0;

  // {sel_init,last_round,state_en,kexp_en,out_valid,busy,in_ready,round,rcon}
  function automatic logic [18:0] row(input logic sel, input logic last, input logic sen,
                                      input logic ken, input logic ov, input logic bz,
                                      input logic ir, input logic [3:0] rnd, input logic [7:0] rc);
    return {sel, last, sen, ken, ov, bz, ir, rnd, rc};
  endfunction

  function automatic logic [18:0] obs();
    if (use14)
      return {b_sel_init, b_last_round, b_state_en, b_kexp_en, b_out_valid, b_busy,
              b_in_ready, b_round, b_rcon};
    return {a_sel_init, a_last_round, a_state_en, a_kexp_en, a_out_valid, a_busy,
            a_in_ready, a_round, a_rcon};
  endfunction

  task automatic check(input string tag);
    logic [18:0] e, o;
    vectors++;
    o = obs();
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic push_idle(input logic ir);
    sb.push_back(row(0, 0, 0, 0, 0, 0, ir, 4'd0, 8'h00));
  endtask

  task automatic push_block(input int nr, input int extra);
    sb.push_back(row(1, 0, 1, 0, 0, 1, 0, 4'd0, 8'h00));
    for (int k = 1; k <= nr; k++)
      sb.push_back(row(0, k == nr, 1, 1, 0, 1, 0, 4'(k), RCON_T[k]));
    for (int j = 0; j <= extra; j++)
      sb.push_back(row(0, 0, 0, 0, 1, 1, 0, 4'(nr), RCON_T[nr]));
    push_idle(1'b1);
  endtask

  // Sample the cycle's outputs at the falling edge, then drive the inputs
  // that the next rising edge will see.
  task automatic step(input logic ld_v, input logic ab_v, input logic or_v, input string tag);
    @(negedge clk);
    check(tag);
    if (use14) ld14 = ld_v;
    else       ld   = ld_v;
    abort     = ab_v;
    out_ready = or_v;
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; ld14 = 1'b0; abort = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b0;

    // reset state: everything low, in_ready too while rst is asserted
    @(negedge clk);
    sb.push_back(19'd0);
    check("reset_state");
    rst = 1'b1;
    push_idle(1'b1);
    @(negedge clk);
    check("idle_after_reset");

    // single NR=10 block: INIT, rounds 1..10, out_valid in cycle 12, IDLE
    ld = 1'b1;
    push_block(10, 0);
    for (int c = 1; c <= 13; c++) step(1'b0, 1'b0, 1'b1, "nr10_block");

    // NR=14 block: rcon reaches 4D in round 14, out_valid in cycle 16
    use14 = 1'b1;
    ld14 = 1'b1;
    push_block(14, 0);
    for (int c = 1; c <= 17; c++) step(1'b0, 1'b0, 1'b1, "nr14_block");
    use14 = 1'b0;

    // abort while round==5, then an immediate reload that completes
    ld = 1'b1;
    sb.push_back(row(1, 0, 1, 0, 0, 1, 0, 4'd0, 8'h00));
    for (int k = 1; k <= 5; k++)
      sb.push_back(row(0, 0, 1, 1, 0, 1, 0, 4'(k), RCON_T[k]));
    push_idle(1'b1);
    push_block(10, 0);
    for (int c = 1; c <= 5; c++) step(1'b0, 1'b0, 1'b1, "abort_pre");
    step(1'b0, 1'b1, 1'b1, "abort_round5");
    @(posedge clk);
    #1 abort = 1'b0;
    step(1'b1, 1'b0, 1'b1, "abort_idle");
    for (int c = 1; c <= 13; c++) step(1'b0, 1'b0, 1'b1, "after_abort_block");

    // out_ready low through OUT: held in hold mode, single pulse otherwise
    out_ready = 1'b0;
    ld = 1'b1;
    push_block(10, HOLD);
    for (int c = 1; c <= 13 + HOLD; c++)
      step(1'b0, 1'b0, (HOLD > 0) && (c >= 12 + HOLD), "out_hold");
    out_ready = 1'b1;

    // ld held high for three blocks: one accept per NR+3 cycles
    ld = 1'b1;
    for (int b = 0; b < 3; b++) push_block(10, 0);
    for (int c = 1; c <= 39; c++) step(c < 39, 1'b0, 1'b1, "ld_held");

    // ld together with abort in IDLE: not accepted, stays IDLE
    ld = 1'b1;
    abort = 1'b1;
    #1;
    push_idle(1'b0);
    check("ld_abort_in_ready");
    push_idle(1'b0);
    push_idle(1'b0);
    step(1'b1, 1'b1, 1'b1, "ld_abort_idle");
    step(1'b0, 1'b0, 1'b1, "ld_abort_idle");
    push_idle(1'b1);
    step(1'b0, 1'b0, 1'b1, "ld_abort_release");

    // asynchronous reset in the middle of round 4
    ld = 1'b1;
    sb.push_back(row(1, 0, 1, 0, 0, 1, 0, 4'd0, 8'h00));
    for (int k = 1; k <= 3; k++)
      sb.push_back(row(0, 0, 1, 1, 0, 1, 0, 4'(k), RCON_T[k]));
    for (int c = 1; c <= 4; c++) step(1'b0, 1'b0, 1'b1, "pre_async_reset");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    sb.push_back(19'd0);
    check("async_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    push_idle(1'b1);
    check("post_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
